// File: rtl/uart_tx.sv
// uart_tx: serial transmitter framing one DATA_WIDTH-bit word as
// start bit, LSB-first data bits, optional parity bit and one stop bit.
// Each bit lasts Prescale clock cycles. Prescale 0 behaves as 1.
// TX_OUT and Busy are driven straight from flops.
module uart_tx #(
  parameter int DATA_WIDTH    = 8,
  parameter int BIT_CNT_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [4:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

  logic [2:0]               state;
  logic [DATA_WIDTH-1:0]    shift_reg;
  logic [4:0]               edge_cnt;
  logic [4:0]               presc_q;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt;
  logic                     par_en_q;
  logic                     par_bit_q;
  logic                     bit_done;
  logic [4:0]               presc_eff;
  logic                     par_calc;

  // End of the current bit period and the values latched at acceptance
  always_comb begin
    bit_done  = (edge_cnt == (presc_q - 5'd1));
    presc_eff = (Prescale == 5'd0) ? 5'd1 : Prescale;
    par_calc  = (^P_DATA) ^ PAR_TYP;
  end

  // Frame sequencer. TX_OUT is loaded with the value of the bit being
  // entered on the same edge that changes state, so the line is never
  // decoded from state and has no combinational path to the pin.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
      shift_reg <= '0;
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT   <= 1'b1;
          Busy     <= 1'b0;
          edge_cnt <= '0;
          bit_cnt  <= '0;
          if (Data_Valid) begin
            state     <= START;
            TX_OUT    <= 1'b0;
            Busy      <= 1'b1;
            shift_reg <= P_DATA;
            presc_q   <= presc_eff;
            par_en_q  <= PAR_EN;
            par_bit_q <= par_calc;
          end
        end
        START: begin
          if (bit_done) begin
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            state     <= DATA;
            TX_OUT    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end else begin
            edge_cnt <= edge_cnt + 5'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            edge_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              if (par_en_q) begin
                state  <= PARITY;
                TX_OUT <= par_bit_q;
              end else begin
                state  <= STOP;
                TX_OUT <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              TX_OUT    <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            edge_cnt <= edge_cnt + 5'd1;
          end
        end
        PARITY: begin
          if (bit_done) begin
            edge_cnt <= '0;
            state    <= STOP;
            TX_OUT   <= 1'b1;
          end else begin
            edge_cnt <= edge_cnt + 5'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            edge_cnt <= '0;
            state    <= IDLE;
            Busy     <= 1'b0;
            TX_OUT   <= 1'b1;
          end else begin
            edge_cnt <= edge_cnt + 5'd1;
          end
        end
        default: begin
          state    <= IDLE;
          TX_OUT   <= 1'b1;
          Busy     <= 1'b0;
          edge_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule
